// File: rtl/collatz_datapath.sv
// collatz_datapath: working register X, status flags, step counter,
// sticky overflow and optional peak tracker (macro PEAK_TRACK_EN).
module collatz_datapath #(
  parameter int WIDTH = 8,
  parameter int STEPW = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] X_in,
  input  logic             SEL,
  input  logic             WEN,
  input  logic [1:0]       FS,
  output logic             One,
  output logic             X0,
  output logic [WIDTH-1:0] X_out,
  output logic [STEPW-1:0] steps,
  output logic             ovf,
  output logic [WIDTH-1:0] peak
);

  logic [WIDTH-1:0] x;
  logic [WIDTH+1:0] ext;
  logic [WIDTH+1:0] res;
  logic [WIDTH-1:0] nx;
  logic             wr;
  logic             carry;

  assign ext   = {2'b00, x};
  assign nx    = res[WIDTH-1:0];
  assign wr    = SEL && WEN;
  assign carry = FS[1] && (|res[WIDTH+1:WIDTH]);

  // next-X function at WIDTH+2 bits so overflow is visible
  always_comb begin
    res = ext;
    unique case (FS)
      2'b00: res = ext;
      2'b01: res = ext >> 1;
      2'b10: res = ext + 1'b1;
      2'b11: res = (ext << 1) + ext;
    endcase
  end

  // working register, step counter and sticky overflow
  always_ff @(posedge CLK) begin
    if (reset) begin
      x     <= '0;
      steps <= '0;
      ovf   <= 1'b0;
    end else if (!SEL) begin
      x     <= X_in;
      steps <= '0;
      ovf   <= 1'b0;
    end else if (wr) begin
      x <= nx;
      if (FS != 2'b00 && steps != {STEPW{1'b1}})
        steps <= steps + 1'b1;
      if (carry)
        ovf <= 1'b1;
    end
  end

`ifdef PEAK_TRACK_EN
  logic [WIDTH-1:0] pk;

  // largest truncated X seen since the last load
  always_ff @(posedge CLK) begin
    if (reset)
      pk <= '0;
    else if (!SEL)
      pk <= X_in;
    else if (wr && nx > pk)
      pk <= nx;
  end

  assign peak = pk;
`else
  assign peak = '0;
`endif

  assign X_out = x;
  assign One   = (x == WIDTH'(1));
  assign X0    = x[0];

endmodule

// File: tb/tb_collatz_datapath.sv
// tb_collatz_datapath: table vectors, corner sequences and a
// randomized run against an arithmetic reference model.
module tb_collatz_datapath;

`ifdef PEAK_TRACK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] X_in = '0;
  logic       SEL = 1'b0;
  logic       WEN = 1'b0;
  logic [1:0] FS = '0;
  logic       One, X0, ovf;
  logic [7:0] X_out, steps, peak;
  logic       One2, X02, ovf2;
  logic [7:0] X_out2, peak2;
  logic [1:0] steps2;

  int n_cmp = 0;
  int n_bad = 0;

  int m_x, m_steps, m_peak;
  bit m_ovf;

  always #5 CLK = ~CLK;

  collatz_datapath #(.WIDTH(8), .STEPW(8)) dut (
    .CLK(CLK), .reset(reset), .X_in(X_in), .SEL(SEL),
    .WEN(WEN), .FS(FS), .One(One), .X0(X0), .X_out(X_out),
    .steps(steps), .ovf(ovf), .peak(peak)
  );

  collatz_datapath #(.WIDTH(8), .STEPW(2)) dut2 (
    .CLK(CLK), .reset(reset), .X_in(X_in), .SEL(SEL),
    .WEN(WEN), .FS(FS), .One(One2), .X0(X02), .X_out(X_out2),
    .steps(steps2), .ovf(ovf2), .peak(peak2)
  );

  typedef struct {
    bit       rst;
    bit       sel;
    bit       wen;
    bit [1:0] fs;
    int       xin;
    int       ex;
    int       es;
    bit       eo;
    int       ep;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // reference model: spec rules in plain integer arithmetic
  task automatic model(input bit r, input bit s, input bit w,
                       input int f, input int xin);
    int full;
    if (r) begin
      m_x = 0; m_steps = 0; m_ovf = 0; m_peak = 0;
    end else if (!s) begin
      m_x = xin; m_steps = 0; m_ovf = 0; m_peak = xin;
    end else if (w) begin
      case (f)
        1: full = m_x / 2;
        2: full = m_x + 1;
        3: full = 3 * m_x;
        default: full = m_x;
      endcase
      if (full > 255) m_ovf = 1;
      m_x = full % 256;
      if (f != 0) m_steps++;
      if (m_x > m_peak) m_peak = m_x;
    end
  endtask

  task automatic apply(input bit r, input bit s, input bit w,
                       input int f, input int xin);
    @(negedge CLK);
    reset = r; SEL = s; WEN = w;
    FS = 2'(f); X_in = 8'(xin);
    @(posedge CLK);
    model(r, s, w, f, xin);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".x"}, int'(X_out), m_x);
    chk({tag, ".one"}, int'(One), int'(m_x == 1));
    chk({tag, ".x0"}, int'(X0), m_x % 2);
    chk({tag, ".steps"}, int'(steps), sat(m_steps, 255));
    chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
    chk({tag, ".peak"}, int'(peak), PK ? m_peak : 0);
    chk({tag, ".steps2"}, int'(steps2), sat(m_steps, 3));
  endtask

  function automatic vec_t mk(input bit r, input bit s, input bit w,
                              input int f, input int xin, input int ex,
                              input int es, input bit eo, input int ep);
    vec_t v;
    v.rst = r; v.sel = s; v.wen = w; v.fs = 2'(f); v.xin = xin;
    v.ex = ex; v.es = es; v.eo = eo; v.ep = ep;
    return v;
  endfunction

  initial begin
    tbl.push_back(mk(1, 0, 0, 0,   0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 0, 0, 0,   6,   6, 0, 0,   6));
    tbl.push_back(mk(0, 1, 1, 1,   0,   3, 1, 0,   6));
    tbl.push_back(mk(0, 1, 1, 3,   0,   9, 2, 0,   9));
    tbl.push_back(mk(0, 1, 1, 2,   0,  10, 3, 0,  10));
    tbl.push_back(mk(0, 1, 1, 1,   0,   5, 4, 0,  10));
    tbl.push_back(mk(0, 0, 1, 3, 100, 100, 0, 0, 100));
    tbl.push_back(mk(0, 1, 1, 3,   0,  44, 1, 1, 100));
    tbl.push_back(mk(0, 1, 1, 1,   0,  22, 2, 1, 100));
    tbl.push_back(mk(0, 0, 0, 0,   7,   7, 0, 0,   7));
    tbl.push_back(mk(0, 0, 0, 0,   9,   9, 0, 0,   9));
    tbl.push_back(mk(0, 1, 0, 3,   0,   9, 0, 0,   9));
    tbl.push_back(mk(0, 1, 0, 3,   0,   9, 0, 0,   9));
    tbl.push_back(mk(0, 1, 0, 3,   0,   9, 0, 0,   9));
    tbl.push_back(mk(0, 1, 1, 0,   0,   9, 0, 0,   9));
    tbl.push_back(mk(0, 0, 0, 0,   2,   2, 0, 0,   2));
    tbl.push_back(mk(0, 1, 1, 1,   0,   1, 1, 0,   2));
    tbl.push_back(mk(0, 0, 0, 0,   0,   0, 0, 0,   0));
    tbl.push_back(mk(0, 1, 1, 1,   0,   0, 1, 0,   0));
    tbl.push_back(mk(0, 1, 1, 3,   0,   0, 2, 0,   0));
    tbl.push_back(mk(0, 0, 0, 0,  27,  27, 0, 0,  27));
    tbl.push_back(mk(0, 1, 1, 3,   0,  81, 1, 0,  81));
    tbl.push_back(mk(0, 1, 1, 3,   0, 243, 2, 0, 243));
    tbl.push_back(mk(1, 1, 1, 3,  55,   0, 0, 0,   0));

    foreach (tbl[i]) begin
      vec_t v;
      string t;
      v = tbl[i];
      t = $sformatf("tbl%0d", i);
      apply(v.rst, v.sel, v.wen, v.fs, v.xin);
      chk({t, ".x"}, int'(X_out), v.ex);
      chk({t, ".one"}, int'(One), int'(v.ex == 1));
      chk({t, ".x0"}, int'(X0), v.ex % 2);
      chk({t, ".steps"}, int'(steps), v.es);
      chk({t, ".ovf"}, int'(ovf), int'(v.eo));
      chk({t, ".peak"}, int'(peak), PK ? v.ep : 0);
      chk({t, ".steps2"}, int'(steps2), sat(v.es, 3));
    end

    // STEPW=2 saturation: five increments from 0
    apply(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 1, 1, 2, 0);
    chk("sat.x", int'(X_out), 5);
    chk("sat.steps8", int'(steps), 5);
    chk("sat.steps2", int'(steps2), 3);

    // long increment run: 8-bit counter saturates, X wraps with ovf
    apply(0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) apply(0, 1, 1, 2, 0);
    chk_model("long");
    chk("long.steps_sat", int'(steps), 255);
    chk("long.ovf", int'(ovf), 1);

    // randomized operation against the model
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit r, s, w;
      int f, xin;
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 7) != 0);
      w = ($urandom_range(0, 3) != 0);
      f = $urandom_range(0, 3);
      xin = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) xin = $urandom_range(0, 8);
      apply(r, s, w, f, xin);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
